reflex_round_ctrl: RTL and testbench
====================================

REFLEX_ROUND_CTRL -- requirements
Module: reflex_round_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000, meaning clk cycles per millisecond tick (legal range >= 2).
REQ-002 SHALL have parameter MIN_WAIT_MS, default 1000, meaning fixed part of the pre-GO delay in ms (legal range >= 1).
REQ-003 SHALL have parameter TIMEOUT_MS, default 9999, meaning the reaction window limit in ms (legal range 1..16383).
REQ-004 SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port start, input, 1 bit: synchronized request to begin a round.
REQ-007 SHALL have port react, input, 1 bit: synchronized, debounced player button level.
REQ-008 SHALL have port rnd, input, 12 bits: random value from the LFSR generator.
REQ-009 SHALL have port led_go, output, 1 bit: GO indicator; high only in GO.
REQ-010 SHALL have port busy, output, 1 bit: high in WAIT and GO.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse on entry to RESULT.
REQ-012 SHALL have port false_start, output, 1 bit: last round ended by a press during WAIT.
REQ-013 SHALL have port timeout, output, 1 bit: last round ended by reaching TIMEOUT_MS.
REQ-014 SHALL have port react_ms, output, 14 bits: measured reaction time in ms.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, GO and RESULT; all outputs SHALL be registered.
REQ-016 SHALL derive react_rise = react AND NOT (react registered one cycle earlier); only react_rise SHALL count as a press.
REQ-017 In IDLE or RESULT, start=1 SHALL load delay = MIN_WAIT_MS + rnd (13-bit, zero-extended, no overflow), clear false_start, timeout and react_ms, clear the ms prescaler, and enter WAIT.
REQ-018 The ms prescaler SHALL count 0..TICK_DIV-1 while in WAIT or GO, issuing one tick when it wraps; it SHALL restart from 0 on entry to WAIT and on entry to GO.
REQ-019 In WAIT, each tick SHALL decrement delay; a tick with delay==1 SHALL enter GO, so WAIT lasts exactly (MIN_WAIT_MS+rnd)*TICK_DIV cycles.
REQ-020 In WAIT, react_rise SHALL set false_start and enter RESULT; if it coincides with the final tick, false start SHALL win.
REQ-021 In GO, each tick SHALL increment react_ms; react_rise SHALL freeze react_ms and enter RESULT.
REQ-022 In GO, a tick that makes react_ms equal TIMEOUT_MS SHALL set timeout and enter RESULT; if react_rise occurs in that same cycle, react SHALL win with react_ms=TIMEOUT_MS and timeout=0.
REQ-023 start SHALL be ignored in WAIT and GO; react SHALL be ignored in IDLE and RESULT.
REQ-024 In RESULT, react_ms, false_start and timeout SHALL hold until the next accepted start.
REQ-025 A button already held when entering WAIT SHALL NOT cause a false start until released and pressed again.

Reset
REQ-026 rst=1 SHALL, on the next clk edge and regardless of state (including mid-round), force IDLE, clear the prescaler, delay and the react edge register, and drive led_go=0, busy=0, done=0, false_start=0, timeout=0, react_ms=0.
REQ-027 rst SHALL take priority over start and react in the same cycle.

Verification (TICK_DIV=4, MIN_WAIT_MS=2, TIMEOUT_MS=20)
REQ-028 Nominal: start with rnd=3 -> busy=1; led_go rises exactly 20 cycles after WAIT entry; react_rise 30 cycles after GO entry -> done pulse, react_ms=7, false_start=0, timeout=0.
REQ-029 False start: start, rnd=0, react_rise 5 cycles into WAIT -> led_go never asserts, false_start=1, done pulse, react_ms=0.
REQ-030 Timeout: enter GO, hold react=0 -> after 80 cycles react_ms=20, timeout=1, led_go=0, done pulse.
REQ-031 Coincidence: react_rise on the final WAIT tick -> false_start=1; react_rise on the tick that reaches 20 ms in GO -> react_ms=20, timeout=0.
REQ-032 Reset mid-GO: assert rst for one cycle in GO -> next cycle all outputs 0, state IDLE; a following start runs a normal round.
REQ-033 Held button and ignored start: react held high through start, then start pulsed during WAIT -> no false start and no restart; release then press in GO measures normally.

Source files
------------

// File: rtl/reflex_round_ctrl.sv
// reflex_round_ctrl
// Round controller for a reaction-time game. A round starts with a random
// pre-GO delay (MIN_WAIT_MS + rnd milliseconds), then lights the GO lamp and
// measures how many milliseconds pass until the player presses the button.
// Pressing early is a false start; not pressing within TIMEOUT_MS is a timeout.
//
// Parameters:
//   TICK_DIV    - clk cycles per millisecond tick (>= 2)
//   MIN_WAIT_MS - fixed part of the pre-GO delay in ms (>= 1)
//   TIMEOUT_MS  - reaction window limit in ms (1..16383)
//
// Ports:
//   clk         - system clock, rising edge
//   rst         - synchronous active-high reset
//   start       - request to begin a round (accepted in IDLE and RESULT)
//   react       - debounced player button level
//   rnd         - 12-bit random value added to the pre-GO delay
//   led_go      - GO lamp, high only while waiting for the reaction
//   busy        - high while a round is running (WAIT or GO)
//   done        - one-cycle pulse when a round finishes
//   false_start - last round ended by a press before GO
//   timeout     - last round ended because the window expired
//   react_ms    - measured reaction time in milliseconds
module reflex_round_ctrl #(
   parameter int TICK_DIV    = 100000,
   parameter int MIN_WAIT_MS = 1000,
   parameter int TIMEOUT_MS  = 9999
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        react,
   input  logic [11:0] rnd,
   output logic        led_go,
   output logic        busy,
   output logic        done,
   output logic        false_start,
   output logic        timeout,
   output logic [13:0] react_ms
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      GO,
      RESULT
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [PW-1:0] presc;
   logic [PW-1:0] presc_next;
   logic [12:0]   delay;
   logic [12:0]   delay_next;
   logic          react_q;
   logic          react_rise;
   logic          tick;
   logic [13:0]   ms_inc;
   logic [13:0]   react_ms_next;
   logic          false_start_next;
   logic          timeout_next;
   logic          done_next;
   logic          led_go_next;
   logic          busy_next;

   // A press is only the rising edge of the button level, so a button that is
   // already held when a round starts cannot trigger a false start until it
   // has been released and pressed again.
   assign react_rise = react & ~react_q;

   // The millisecond tick fires on the last prescaler count; the prescaler
   // wraps to zero on that same edge.
   assign tick   = (presc == PW'(TICK_DIV - 1));
   assign ms_inc = react_ms + 14'd1;

   // State and every output are registered here. Reset wins over everything,
   // including a start or a press in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         presc       <= '0;
         delay       <= '0;
         react_q     <= 1'b0;
         led_go      <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         false_start <= 1'b0;
         timeout     <= 1'b0;
         react_ms    <= '0;
      end else begin
         state       <= state_next;
         presc       <= presc_next;
         delay       <= delay_next;
         react_q     <= react;
         led_go      <= led_go_next;
         busy        <= busy_next;
         done        <= done_next;
         false_start <= false_start_next;
         timeout     <= timeout_next;
         react_ms    <= react_ms_next;
      end
   end

   // Next-state and next-output logic. WAIT counts the delay down once per
   // millisecond and a press there always wins over the final tick. GO counts
   // the reaction time up; a press on the tick that reaches the limit still
   // counts as a valid reaction of exactly TIMEOUT_MS. Result flags simply
   // hold in IDLE/RESULT until the next accepted start clears them.
   always_comb begin
      state_next       = state;
      presc_next       = presc;
      delay_next       = delay;
      react_ms_next    = react_ms;
      false_start_next = false_start;
      timeout_next     = timeout;
      done_next        = 1'b0;

      case (state)
         IDLE, RESULT: begin
            if (start) begin
               delay_next       = 13'(MIN_WAIT_MS) + 13'(rnd);
               false_start_next = 1'b0;
               timeout_next     = 1'b0;
               react_ms_next    = '0;
               presc_next       = '0;
               state_next       = WAIT;
            end
         end

         WAIT: begin
            presc_next = tick ? '0 : presc + 1'b1;
            if (react_rise) begin
               false_start_next = 1'b1;
               done_next        = 1'b1;
               state_next       = RESULT;
            end else if (tick) begin
               delay_next = delay - 13'd1;
               if (delay == 13'd1) begin
                  presc_next = '0;
                  state_next = GO;
               end
            end
         end

         GO: begin
            presc_next = tick ? '0 : presc + 1'b1;
            if (tick) begin
               react_ms_next = ms_inc;
            end
            if (react_rise) begin
               done_next  = 1'b1;
               state_next = RESULT;
            end else if (tick && (ms_inc == 14'(TIMEOUT_MS))) begin
               timeout_next = 1'b1;
               done_next    = 1'b1;
               state_next   = RESULT;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase

      led_go_next = (state_next == GO);
      busy_next   = (state_next == WAIT) || (state_next == GO);
   end

endmodule

// File: tb/tb_reflex_round_ctrl.sv
// tb_reflex_round_ctrl
// Self-checking bench for reflex_round_ctrl with TICK_DIV=4, MIN_WAIT_MS=2,
// TIMEOUT_MS=20. A behavioural model tracks each round as elapsed cycles in
// the current phase and derives milliseconds by division, and is compared
// against every DUT output on each falling edge. Directed scenarios add
// explicit constant checks; a randomized phase follows.
module tb_reflex_round_ctrl;

   localparam int TICK = 4;
   localparam int MINW = 2;
   localparam int TMO  = 20;

   localparam int M_IDLE   = 0;
   localparam int M_WAIT   = 1;
   localparam int M_GO     = 2;
   localparam int M_RESULT = 3;

   logic        clk;
   logic        rst;
   logic        start;
   logic        react;
   logic [11:0] rnd;
   logic        led_go;
   logic        busy;
   logic        done;
   logic        false_start;
   logic        timeout;
   logic [13:0] react_ms;

   int total;
   int bad;
   bit chk_en;
   int cyc;

   typedef struct packed {
      int          mode;
      int          cnt;
      int          len;
      logic        prev;
      logic        led;
      logic        busy;
      logic        done;
      logic        fs;
      logic        to;
      logic [13:0] ms;
   } model_t;

   model_t m;

   reflex_round_ctrl #(
      .TICK_DIV   (TICK),
      .MIN_WAIT_MS(MINW),
      .TIMEOUT_MS (TMO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .react      (react),
      .rnd        (rnd),
      .led_go     (led_go),
      .busy       (busy),
      .done       (done),
      .false_start(false_start),
      .timeout    (timeout),
      .react_ms   (react_ms)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a round is described by its phase and the number of
   // cycles spent in it. WAIT lasts (MINW+rnd)*TICK cycles; in GO the
   // reaction time after cycle g is floor((g+1)/TICK) milliseconds.
   function automatic model_t modelStep(model_t c, logic r, logic s, logic rc, logic [11:0] n);
      model_t x;
      int     ticks;
      logic   rise;
      x      = c;
      rise   = rc && !c.prev;
      x.prev = rc;
      x.done = 1'b0;
      if (r) begin
         x = '0;
         return x;
      end
      case (c.mode)
         M_IDLE, M_RESULT: begin
            if (s) begin
               x.mode = M_WAIT;
               x.cnt  = 0;
               x.len  = (MINW + int'(n)) * TICK;
               x.fs   = 1'b0;
               x.to   = 1'b0;
               x.ms   = '0;
            end
         end
         M_WAIT: begin
            if (rise) begin
               x.fs   = 1'b1;
               x.done = 1'b1;
               x.mode = M_RESULT;
            end else if (c.cnt == c.len - 1) begin
               x.mode = M_GO;
               x.cnt  = 0;
            end else begin
               x.cnt = c.cnt + 1;
            end
         end
         default: begin
            ticks = (c.cnt + 1) / TICK;
            x.ms  = 14'(ticks);
            if (rise) begin
               x.done = 1'b1;
               x.mode = M_RESULT;
            end else if (ticks == TMO) begin
               x.to   = 1'b1;
               x.done = 1'b1;
               x.mode = M_RESULT;
            end else begin
               x.cnt = c.cnt + 1;
            end
         end
      endcase
      x.led  = (x.mode == M_GO);
      x.busy = (x.mode == M_WAIT) || (x.mode == M_GO);
      return x;
   endfunction

   // Advance the model on the same edge the DUT samples its inputs.
   initial m = '0;
   always @(posedge clk) begin
      m <= modelStep(m, rst, start, react, rnd);
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total = total + 1;
      if (got !== exp) begin
         bad = bad + 1;
         $display("[TB] FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Compare all outputs against the model away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         checkOutput("mdl_led_go", 32'(led_go), 32'(m.led));
         checkOutput("mdl_busy", 32'(busy), 32'(m.busy));
         checkOutput("mdl_done", 32'(done), 32'(m.done));
         checkOutput("mdl_false_start", 32'(false_start), 32'(m.fs));
         checkOutput("mdl_timeout", 32'(timeout), 32'(m.to));
         checkOutput("mdl_react_ms", 32'(react_ms), 32'(m.ms));
      end
   end

   // Drive all inputs and hold them for a number of falling edges.
   task automatic applyStimulus(input logic r, input logic s, input logic rc,
                                input logic [11:0] n, input int cycles);
      rst   = r;
      start = s;
      react = rc;
      rnd   = n;
      repeat (cycles) @(negedge clk);
   endtask

   // Wait for the GO lamp with a cycle budget; returns cycles waited.
   task automatic waitGo(input int budget, output int waited);
      waited = 0;
      while (!led_go && waited < budget) begin
         @(negedge clk);
         waited = waited + 1;
      end
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      chk_en = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0, 12'd0, 2);
      chk_en = 1'b1;

      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_led_go", 32'(led_go), 32'd0);
      checkOutput("rst_react_ms", 32'(react_ms), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 12'd0, 2);

      // Nominal round, rnd=3: GO after 20 cycles, press 30 cycles into GO.
      applyStimulus(1'b0, 1'b1, 1'b0, 12'd3, 1);
      checkOutput("nom_busy", 32'(busy), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 12'd3, 0);
      waitGo(100, cyc);
      checkOutput("nom_go_latency", 32'(cyc), 32'd20);
      applyStimulus(1'b0, 1'b0, 1'b0, 12'd3, 30);
      applyStimulus(1'b0, 1'b0, 1'b1, 12'd3, 1);
      checkOutput("nom_done", 32'(done), 32'd1);
      checkOutput("nom_react_ms", 32'(react_ms), 32'd7);
      checkOutput("nom_false_start", 32'(false_start), 32'd0);
      checkOutput("nom_timeout", 32'(timeout), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b1, 12'd3, 1);
      checkOutput("nom_done_pulse", 32'(done), 32'd0);
      checkOutput("nom_hold_ms", 32'(react_ms), 32'd7);

      // False start 5 cycles into WAIT.
      applyStimulus(1'b0, 1'b0, 1'b0, 12'd0, 2);
      applyStimulus(1'b0, 1'b1, 1'b0, 12'd0, 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 12'd0, 5);
      applyStimulus(1'b0, 1'b0, 1'b1, 12'd0, 1);
      checkOutput("fs_flag", 32'(false_start), 32'd1);
      checkOutput("fs_done", 32'(done), 32'd1);
      checkOutput("fs_led_go", 32'(led_go), 32'd0);
      checkOutput("fs_react_ms", 32'(react_ms), 32'd0);

      // Timeout: no press for 80 cycles of GO.
      applyStimulus(1'b0, 1'b0, 1'b0, 12'd0, 2);
      applyStimulus(1'b0, 1'b1, 1'b0, 12'd0, 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 12'd0, 0);
      waitGo(100, cyc);
      checkOutput("to_go_latency", 32'(cyc), 32'd8);
      applyStimulus(1'b0, 1'b0, 1'b0, 12'd0, 80);
      checkOutput("to_flag", 32'(timeout), 32'd1);
      checkOutput("to_react_ms", 32'(react_ms), 32'd20);
      checkOutput("to_led_go", 32'(led_go), 32'd0);
      checkOutput("to_done", 32'(done), 32'd1);

      // Press on the final WAIT tick: false start wins.
      applyStimulus(1'b0, 1'b1, 1'b0, 12'd0, 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 12'd0, 7);
      applyStimulus(1'b0, 1'b0, 1'b1, 12'd0, 1);
      checkOutput("cw_false_start", 32'(false_start), 32'd1);
      checkOutput("cw_led_go", 32'(led_go), 32'd0);

      // Press on the tick that reaches the limit: valid reaction of 20 ms.
      applyStimulus(1'b0, 1'b0, 1'b0, 12'd0, 2);
      applyStimulus(1'b0, 1'b1, 1'b0, 12'd0, 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 12'd0, 0);
      waitGo(100, cyc);
      applyStimulus(1'b0, 1'b0, 1'b0, 12'd0, 79);
      applyStimulus(1'b0, 1'b0, 1'b1, 12'd0, 1);
      checkOutput("cg_react_ms", 32'(react_ms), 32'd20);
      checkOutput("cg_timeout", 32'(timeout), 32'd0);
      checkOutput("cg_done", 32'(done), 32'd1);

      // Reset in the middle of GO, then a normal round.
      applyStimulus(1'b0, 1'b0, 1'b0, 12'd1, 2);
      applyStimulus(1'b0, 1'b1, 1'b0, 12'd1, 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 12'd1, 0);
      waitGo(100, cyc);
      applyStimulus(1'b0, 1'b0, 1'b0, 12'd1, 5);
      applyStimulus(1'b1, 1'b1, 1'b1, 12'd1, 1);
      checkOutput("rg_led_go", 32'(led_go), 32'd0);
      checkOutput("rg_busy", 32'(busy), 32'd0);
      checkOutput("rg_react_ms", 32'(react_ms), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 12'd1, 1);
      applyStimulus(1'b0, 1'b1, 1'b0, 12'd2, 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 12'd2, 0);
      waitGo(100, cyc);
      checkOutput("rg_go_latency", 32'(cyc), 32'd16);
      applyStimulus(1'b0, 1'b0, 1'b0, 12'd2, 9);
      applyStimulus(1'b0, 1'b0, 1'b1, 12'd2, 1);
      checkOutput("rg_react_ms2", 32'(react_ms), 32'd2);

      // Button held through start, extra start in WAIT is ignored.
      applyStimulus(1'b0, 1'b0, 1'b1, 12'd1, 2);
      applyStimulus(1'b0, 1'b1, 1'b1, 12'd1, 1);
      applyStimulus(1'b0, 1'b0, 1'b1, 12'd1, 3);
      applyStimulus(1'b0, 1'b1, 1'b1, 12'd5, 1);
      applyStimulus(1'b0, 1'b0, 1'b1, 12'd5, 0);
      waitGo(100, cyc);
      checkOutput("hb_go_latency", 32'(cyc), 32'd8);
      checkOutput("hb_false_start", 32'(false_start), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 12'd5, 4);
      applyStimulus(1'b0, 1'b0, 1'b1, 12'd5, 1);
      checkOutput("hb_react_ms", 32'(react_ms), 32'd1);
      checkOutput("hb_false_start2", 32'(false_start), 32'd0);

      // Largest random delay: 4097 ms of WAIT without overflow.
      applyStimulus(1'b0, 1'b0, 1'b0, 12'd0, 2);
      applyStimulus(1'b0, 1'b1, 1'b0, 12'hFFF, 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 12'hFFF, 0);
      waitGo(20000, cyc);
      checkOutput("big_go_latency", 32'(cyc), 32'd16388);
      applyStimulus(1'b0, 1'b0, 1'b0, 12'hFFF, 80);
      checkOutput("big_timeout", 32'(timeout), 32'd1);

      // Randomized traffic; the model checks every cycle.
      for (int i = 0; i < 6000; i++) begin
         logic r;
         logic s;
         logic rc;
         r  = ($urandom_range(0, 499) == 0);
         s  = ($urandom_range(0, 15) == 0);
         rc = react;
         if (i < 3000) begin
            if ($urandom_range(0, 5) == 0) rc = ~rc;
         end else begin
            if ($urandom_range(0, 39) == 0) rc = ~rc;
         end
         applyStimulus(r, s, rc, 12'($urandom_range(0, 6)), 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
